// File: rtl/fft_mult_pkg.sv
// Shared constants for the FFT butterfly multiplier datapath: product
// width, output format and the rounding/saturation helpers derived from it.
package fft_mult_pkg;

    localparam int W     = 32;
    localparam int OUT_W = 16;
    localparam int FRAC  = 15;

    // Half-LSB of the retained result; adding it before the shift rounds half up.
    function automatic int round_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int out_w);
        return -(1 << (out_w - 1));
    endfunction

    localparam int ROUND_CONST = round_const(FRAC);
    localparam int SAT_MAX     = sat_max(OUT_W);
    localparam int SAT_MIN     = sat_min(OUT_W);

endpackage

// File: rtl/cpa_slice.sv
// Registered N-bit adder slice with carry-in, carry-out and load enable.
// One slice per half of the carry-propagate add.
module cpa_slice #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Capture a + b + cin when the stage is allowed to load; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/wallace_cpa_round.sv
// Final carry-propagate, round-half-up and saturation stage of the FFT
// butterfly multiplier. Three pipeline stages with a valid/ready chain:
// low-half add, high-half add, round/saturate.
module wallace_cpa_round
    import fft_mult_pkg::*;
#(
    parameter int W     = fft_mult_pkg::W,
    parameter int OUT_W = fft_mult_pkg::OUT_W,
    parameter int FRAC  = fft_mult_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_vec,
    input  logic [W-1:0]     c_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int HW = W / 2;

    localparam logic signed [W:0] RND    = (W+1)'(round_const(FRAC));
    localparam logic signed [W:0] SAT_HI = (W+1)'(sat_max(OUT_W));
    localparam logic signed [W:0] SAT_LO = (W+1)'(sat_min(OUT_W));

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    logic [HW-1:0] lo1, s_hi1, c_hi1;
    logic          k1;
    logic [HW-1:0] lo2, hi2;
    logic          unused_hi_cout;

    logic [W-1:0]        p2;
    logic signed [W:0]   p_ext, p_rnd, r;
    logic [OUT_W-1:0]    r_data;
    logic                r_sat;

    // Load chain: a stage loads when empty or when its successor loads,
    // so bubbles collapse even while the output is stalled.
    always_comb begin
        ld3 = !v3 || out_ready;
        ld2 = !v2 || ld3;
        ld1 = !v1 || ld2;
    end

    assign in_ready  = ld1;
    assign out_valid = v3;

    // Valid bits advance with their stage's load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // Stage 1: low-half add, carry-out k feeds the high half next cycle.
    cpa_slice #(.N(HW)) u_lo_add (
        .clk  (clk),
        .rst  (rst),
        .load (ld1),
        .a    (s_vec[HW-1:0]),
        .b    (c_vec[HW-1:0]),
        .cin  (1'b0),
        .sum  (lo1),
        .cout (k1)
    );

    // Stage 1: high halves travel alongside the low-half result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_hi1 <= '0;
            c_hi1 <= '0;
        end else if (ld1) begin
            s_hi1 <= s_vec[W-1:HW];
            c_hi1 <= c_vec[W-1:HW];
        end
    end

    // Stage 2: high-half add; its carry-out is dropped so the product wraps mod 2^W.
    cpa_slice #(.N(HW)) u_hi_add (
        .clk  (clk),
        .rst  (rst),
        .load (ld2),
        .a    (s_hi1),
        .b    (c_hi1),
        .cin  (k1),
        .sum  (hi2),
        .cout (unused_hi_cout)
    );

    // Stage 2: low half of the product registered alongside the high add.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo2 <= '0;
        end else if (ld2) begin
            lo2 <= lo1;
        end
    end

    assign p2 = {hi2, lo2};

    // Round half up with an arithmetic shift, then clip to the output range.
    always_comb begin
        p_ext  = $signed({p2[W-1], p2});
        p_rnd  = p_ext + RND;
        r      = p_rnd >>> FRAC;
        r_data = r[OUT_W-1:0];
        r_sat  = 1'b0;
        if (r > SAT_HI) begin
            r_data = OUT_W'(sat_max(OUT_W));
            r_sat  = 1'b1;
        end else if (r < SAT_LO) begin
            r_data = OUT_W'(sat_min(OUT_W));
            r_sat  = 1'b1;
        end
    end

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (ld3) begin
            out_data <= r_data;
            out_sat  <= r_sat;
        end
    end

endmodule

// File: tb/tb_wallace_cpa_round.sv
// Directed and back-pressure bench for wallace_cpa_round (default parameters).
module tb_wallace_cpa_round;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_vec, c_vec;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic        out_sat, out_valid, out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wallace_cpa_round dut (
        .clk       (clk),
        .rst       (rst),
        .s_vec     (s_vec),
        .c_vec     (c_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: signed product, round half up (floor of P/2^15 + 1/2), clip to Q15.
    function automatic logic [16:0] model(input logic [31:0] s, input logic [31:0] c);
        logic [31:0] p;
        longint      ps, r;
        p  = s + c;
        ps = longint'($signed(p));
        r  = (ps + 64'sd16384) >>> 15;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, r[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single vector into an idle pipeline, out_ready high: checks exact latency.
    task automatic send_directed(input string tag, input logic [31:0] s, input logic [31:0] c,
                                 input logic [15:0] exp_data, input logic exp_sat);
        s_vec    = s;
        c_vec    = c;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_lat2"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_sat"}, out_sat, exp_sat);
        tick();
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [16:0] exp_q[$];
        logic [16:0] e, first;
        int sent, done, inflight, cyc, acc_cnt;
        logic acc, drn;

        rst       = 1'b1;
        s_vec     = '0;
        c_vec     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_sat", out_sat, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Rounding, carry across halves, saturation.
        send_directed("rnd_8000", 32'h0000_4000, 32'h0000_4000, 16'h0001, 1'b0);
        send_directed("rnd_3fff", 32'h0000_3FFF, 32'h0000_0000, 16'h0000, 1'b0);
        send_directed("rnd_4000", 32'h0000_2000, 32'h0000_2000, 16'h0001, 1'b0);
        send_directed("rnd_neg",  32'hFFFF_C000, 32'h0000_0000, 16'h0000, 1'b0);
        send_directed("carry",    32'h0000_FFFF, 32'h0000_0001, 16'h0002, 1'b0);
        send_directed("sat_pos",  32'h4000_0000, 32'h0000_0000, 16'h7FFF, 1'b1);
        send_directed("sat_neg",  32'h7FFF_FFFF, 32'h0000_0001, 16'h8000, 1'b1);
        send_directed("wrap",     32'hFFFF_FFFF, 32'h0000_8001, 16'h0001, 1'b0);

        // Back-pressure stream with a scoreboard.
        sent = 0; done = 0; inflight = 0; cyc = 0;
        s_vec = $urandom;
        c_vec = $urandom;
        while (done < 10 && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 10);
            @(negedge clk);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            check("bp_in_ready", in_ready, !(inflight == 3 && !out_ready));
            if (drn) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_data", out_data, e[15:0]);
                    check("bp_sat", out_sat, e[16]);
                end
                done++;
            end
            if (acc) begin
                exp_q.push_back(model(s_vec, c_vec));
                sent++;
            end
            inflight = inflight + int'(acc) - int'(drn);
            tick();
            if (acc) begin
                s_vec = $urandom;
                c_vec = $urandom;
            end
            cyc++;
        end
        check("bp_timeout", cyc < 300, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_no_dup", out_valid, 1'b0);

        // Bubble collapse: stall output, keep feeding, exactly 3 accepted.
        out_ready = 1'b0;
        acc_cnt = 0;
        exp_q.delete();
        s_vec = 32'h0001_0000;
        c_vec = 32'h0000_0000;
        first = model(s_vec, c_vec);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc_cnt++;
                exp_q.push_back(model(s_vec, c_vec));
            end
            if (out_valid) begin
                check("bub_hold_data", out_data, first[15:0]);
                check("bub_hold_sat", out_sat, first[16]);
            end
            acc = in_ready;
            tick();
            if (acc) begin
                s_vec = s_vec + 32'h0001_0000;
                c_vec = c_vec + 32'h0000_8000;
            end
        end
        check("bub_accepted", acc_cnt, 3);
        check("bub_in_ready_low", in_ready, 1'b0);
        check("bub_out_valid", out_valid, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bub_drain_valid", out_valid, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bub_drain_data", out_data, e[15:0]);
            end
            tick();
        end
        check("bub_empty", out_valid, 1'b0);

        // Reset with three items in flight.
        out_ready = 1'b0;
        s_vec = 32'h4000_0000;
        c_vec = 32'h0000_0000;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("rmid_full", out_valid, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_out_valid", out_valid, 1'b0);
        check("rmid_in_ready", in_ready, 1'b1);
        check("rmid_out_data", out_data, 16'h0000);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rmid_no_stale", out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
